// File: rtl/axis_arb_mux2_1.sv
// axis_arb_mux2_1
// Frame-aware 2-to-1 AXI-Stream arbiter/multiplexer. Two AXIS sources are
// merged onto one registered AXIS sink. Once a source is granted, it owns the
// output until the beat carrying its tlast is accepted. Frames from different
// sources are therefore never interleaved. After every frame the arbiter
// spends one cycle in IDLE to make a new decision.
//
// Parameters
//   width     tdata width in bits
//   arb_mode  0 = round-robin between frames, 1 = fixed priority (s0 first)
//
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   s0_axis_*                  source 0: tdata/tvalid/tlast in, tready out
//   s1_axis_*                  source 1: tdata/tvalid/tlast in, tready out
//   m_axis_tdata/tvalid/tlast  registered merged stream out
//   m_axis_tid                 registered source index of the current beat
//   m_axis_tready              sink ready in

module axis_arb_mux2_1 #(
   parameter int width    = 8,
   parameter int arb_mode = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [width-1:0] s0_axis_tdata,
   input  logic             s0_axis_tvalid,
   input  logic             s0_axis_tlast,
   output logic             s0_axis_tready,
   input  logic [width-1:0] s1_axis_tdata,
   input  logic             s1_axis_tvalid,
   input  logic             s1_axis_tlast,
   output logic             s1_axis_tready,
   output logic [width-1:0] m_axis_tdata,
   output logic             m_axis_tvalid,
   output logic             m_axis_tlast,
   output logic             m_axis_tid,
   input  logic             m_axis_tready
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   state_t state;
   logic   last_grant;
   logic   out_free;
   logic   s0_accept;
   logic   s1_accept;

   // The output register can take a new beat when it is empty or when its
   // current beat is leaving this cycle.
   assign out_free       = ~m_axis_tvalid | m_axis_tready;
   assign s0_axis_tready = (state == GRANT0) & out_free;
   assign s1_axis_tready = (state == GRANT1) & out_free;
   assign s0_accept      = s0_axis_tvalid & s0_axis_tready;
   assign s1_accept      = s1_axis_tvalid & s1_axis_tready;

   // Arbitration only happens in IDLE. On contention, round-robin picks the
   // port that did not win last time. last_grant starts at 1 so the first
   // contended decision favours s0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (s0_axis_tvalid && s1_axis_tvalid) begin
                  if (arb_mode == 1 || last_grant) begin
                     state      <= GRANT0;
                     last_grant <= 1'b0;
                  end else begin
                     state      <= GRANT1;
                     last_grant <= 1'b1;
                  end
               end else if (s0_axis_tvalid) begin
                  state      <= GRANT0;
                  last_grant <= 1'b0;
               end else if (s1_axis_tvalid) begin
                  state      <= GRANT1;
                  last_grant <= 1'b1;
               end
            end
            GRANT0: begin
               if (s0_accept && s0_axis_tlast) begin
                  state <= IDLE;
               end
            end
            GRANT1: begin
               if (s1_accept && s1_axis_tlast) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output register. Only the granted source can be accepted, so at most one
   // of the accept strobes is high. When no beat is accepted, the held beat is
   // retired as soon as the sink takes it. Otherwise it is kept stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tid    <= 1'b0;
      end else if (s0_accept) begin
         m_axis_tdata  <= s0_axis_tdata;
         m_axis_tvalid <= 1'b1;
         m_axis_tlast  <= s0_axis_tlast;
         m_axis_tid    <= 1'b0;
      end else if (s1_accept) begin
         m_axis_tdata  <= s1_axis_tdata;
         m_axis_tvalid <= 1'b1;
         m_axis_tlast  <= s1_axis_tlast;
         m_axis_tid    <= 1'b1;
      end else if (m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axis_arb_mux2_1.sv
// tb_axis_arb_mux2_1
// Randomised bench for the 2:1 frame-aware AXIS arbiter. A round-robin
// instance is driven by two random frame sources and a random sink. It is
// checked every cycle against a reference model that tracks the current owner
// and the expected output beat. A per-source scoreboard also confirms that
// every emitted beat is the next accepted beat of the source named by tid.
// A second instance in fixed-priority mode sees s0 and s1 permanently valid.
// In that instance, s1 must never be served.

module tb_axis_arb_mux2_1;

   localparam int W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic [W-1:0] s_data  [2];
   logic         s_valid [2];
   logic         s_last  [2];
   logic         s_ready [2];
   logic [W-1:0] m_data;
   logic         m_valid;
   logic         m_last;
   logic         m_tid;
   logic         m_ready;

   logic [W-1:0] fx_s0_data;
   logic         fx_s0_last;
   logic         fx_s0_ready;
   logic         fx_s1_ready;
   logic [W-1:0] fx_m_data;
   logic         fx_m_valid;
   logic         fx_m_last;
   logic         fx_m_tid;

   axis_arb_mux2_1 #(.width(W), .arb_mode(0)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .s0_axis_tdata(s_data[0]), .s0_axis_tvalid(s_valid[0]),
      .s0_axis_tlast(s_last[0]), .s0_axis_tready(s_ready[0]),
      .s1_axis_tdata(s_data[1]), .s1_axis_tvalid(s_valid[1]),
      .s1_axis_tlast(s_last[1]), .s1_axis_tready(s_ready[1]),
      .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tlast(m_last),
      .m_axis_tid(m_tid), .m_axis_tready(m_ready)
   );

   axis_arb_mux2_1 #(.width(W), .arb_mode(1)) u_dut_fixed (
      .clk(clk), .rst_n(rst_n),
      .s0_axis_tdata(fx_s0_data), .s0_axis_tvalid(1'b1),
      .s0_axis_tlast(fx_s0_last), .s0_axis_tready(fx_s0_ready),
      .s1_axis_tdata(8'h20), .s1_axis_tvalid(1'b1),
      .s1_axis_tlast(1'b1), .s1_axis_tready(fx_s1_ready),
      .m_axis_tdata(fx_m_data), .m_axis_tvalid(fx_m_valid), .m_axis_tlast(fx_m_last),
      .m_axis_tid(fx_m_tid), .m_axis_tready(1'b1)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state: owner -1 means no frame is owned (decision cycle).
   int           owner;
   int           last_winner;
   logic         mv, ml, mt;
   logic [W-1:0] md;
   logic         acc [2];
   int           left [2];
   logic [W:0]   sbq0 [$];
   logic [W:0]   sbq1 [$];

   logic fx_idx;
   logic fx_rdy_s;
   int   fx_k;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic modelReset();
      owner       = -1;
      last_winner = 1;
      mv = 1'b0; ml = 1'b0; mt = 1'b0; md = '0;
      for (int x = 0; x < 2; x++) begin
         acc[x]     = 1'b0;
         left[x]    = 0;
         s_valid[x] = 1'b0;
         s_last[x]  = 1'b0;
         s_data[x]  = '0;
      end
      m_ready = 1'b0;
      sbq0.delete();
      sbq1.delete();
      fx_idx     = 1'b0;
      fx_rdy_s   = 1'b0;
      fx_k       = 0;
      fx_s0_data = 8'h10;
      fx_s0_last = 1'b0;
   endtask

   // Advance the model by one clock edge, using the inputs held across it.
   task automatic modelStep();
      logic rdy;
      for (int x = 0; x < 2; x++) begin
         rdy    = (owner == x) && (!mv || m_ready);
         acc[x] = rdy && s_valid[x];
         if (acc[x]) begin
            if (x == 0) sbq0.push_back({s_last[x], s_data[x]});
            else        sbq1.push_back({s_last[x], s_data[x]});
         end
      end
      if (acc[0] || acc[1]) begin
         md = acc[0] ? s_data[0] : s_data[1];
         ml = acc[0] ? s_last[0] : s_last[1];
         mt = acc[1];
         mv = 1'b1;
      end else if (m_ready) begin
         mv = 1'b0;
      end
      if (owner < 0) begin
         if (s_valid[0] && s_valid[1]) owner = 1 - last_winner;
         else if (s_valid[0])          owner = 0;
         else if (s_valid[1])          owner = 1;
         if (owner >= 0) last_winner = owner;
      end else if (acc[owner] && s_last[owner]) begin
         owner = -1;
      end
      if (fx_rdy_s) fx_idx = ~fx_idx;
   endtask

   // Random AXIS sources (valid held until accepted) and a random sink.
   task automatic applyStimulus(input int pv, input int pr);
      for (int x = 0; x < 2; x++) begin
         if (!s_valid[x] || acc[x]) begin
            if ($urandom_range(99) < pv) begin
               if (left[x] == 0) left[x] = $urandom_range(1, 4);
               s_data[x]  = W'($urandom);
               s_last[x]  = (left[x] == 1);
               left[x]    = left[x] - 1;
               s_valid[x] = 1'b1;
            end else begin
               s_valid[x] = 1'b0;
            end
         end
      end
      m_ready    = ($urandom_range(99) < pr);
      fx_s0_data = fx_idx ? 8'h11 : 8'h10;
      fx_s0_last = fx_idx;
   endtask

   task automatic checkCycle();
      logic [W:0] beat;
      checkOutput("m_valid", m_valid, mv);
      checkOutput("m_data", m_data, md);
      checkOutput("m_last", m_last, ml);
      checkOutput("m_tid", m_tid, mt);
      checkOutput("s0_ready", s_ready[0], (owner == 0) && (!mv || m_ready));
      checkOutput("s1_ready", s_ready[1], (owner == 1) && (!mv || m_ready));
      if (m_valid && m_ready) begin
         checkOutput("sb_avail", (m_tid ? sbq1.size() : sbq0.size()) > 0, 1);
         if (m_tid ? sbq1.size() > 0 : sbq0.size() > 0) begin
            beat = m_tid ? sbq1.pop_front() : sbq0.pop_front();
            checkOutput("sb_beat", {m_last, m_data}, beat);
         end
      end
      fx_rdy_s = fx_s0_ready;
      checkOutput("fix_s1_ready", fx_s1_ready, 0);
      if (fx_m_valid) begin
         checkOutput("fix_tid", fx_m_tid, 0);
         checkOutput("fix_data", fx_m_data, 32'h10 + fx_k % 2);
         checkOutput("fix_last", fx_m_last, fx_k % 2);
         fx_k++;
      end
   endtask

   task automatic runCycles(input int n, input int pv, input int pr);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         modelStep();
         applyStimulus(pv, pr);
         @(negedge clk);
         checkCycle();
      end
   endtask

   task automatic checkResetOutputs(input string phase);
      checkOutput({phase, "_m_valid"}, m_valid, 0);
      checkOutput({phase, "_m_data"}, m_data, 0);
      checkOutput({phase, "_m_last"}, m_last, 0);
      checkOutput({phase, "_m_tid"}, m_tid, 0);
      checkOutput({phase, "_s0_ready"}, s_ready[0], 0);
      checkOutput({phase, "_s1_ready"}, s_ready[1], 0);
      checkOutput({phase, "_fix_m_valid"}, fx_m_valid, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      modelReset();
      repeat (3) @(negedge clk);
      checkResetOutputs("rst");
      rst_n = 1'b1;

      runCycles(300, 70, 75);
      runCycles(200, 90, 40);
      runCycles(100, 95, 100);

      // Try to land the reset in the middle of an s1 frame.
      for (int i = 0; i < 200; i++) begin
         if (owner == 1 && mv) break;
         runCycles(1, 80, 60);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checkResetOutputs("midrst");
      modelReset();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      runCycles(300, 50, 90);
      checkOutput("fix_beats_seen", fx_k > 20, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
